// File: rtl/wq_fetch_pkg.sv
// Shared types and constants for the Wq weight-fetch sequencer.
// Entry layout matches the {data, row_last, last} words buffered in wq_fetch_fifo.
package wq_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam int unsigned NUM_ROWS      = 128;
    localparam int unsigned WORDS_PER_ROW = 16;
    localparam int unsigned ROW_IDX_W     = 7;
    localparam int unsigned WORD_IDX_W    = 4;
    localparam int unsigned WORD_W        = 64;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              row_last;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/wq_fetch_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is presented combinationally.
module wq_fetch_fifo #(
    parameter int unsigned W     = 66,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [W-1:0]                   din,
    input  logic                           pop,
    output logic [W-1:0]                   dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wq_fetch.sv
// Weight-fetch sequencer: reads a run of weight rows from the Wq memory and
// streams them out through a credit-managed FIFO with row/transfer flags.
module wq_fetch #(
    parameter int unsigned WIDTH         = 64,
    parameter logic [31:0] WEIGHT_BASE   = 32'd0,
    parameter int unsigned NUM_ROWS      = 128,
    parameter int unsigned WORDS_PER_ROW = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       row_start,
    input  logic [7:0]       row_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_addr,
    output logic             mem_write_en,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] w_data,
    output logic             w_valid,
    input  logic             w_ready,
    output logic             w_row_last,
    output logic             w_last
);
    import wq_fetch_pkg::*;

    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENTRY_W = WIDTH + 2;

    state_t                state;
    state_t                state_next;
    logic [ROW_IDX_W-1:0]  row_q;
    logic [WORD_IDX_W-1:0] word_q;
    logic [7:0]            rows_left_q;
    logic [31:0]           addr_q;
    logic [31:0]           issue_addr;
    logic                  inflight_q;
    logic                  ret_row_last_q;
    logic                  ret_last_q;
    logic                  drain_armed_q;
    logic                  issue;
    logic                  issue_row_last;
    logic                  issue_last;
    logic                  pop;
    logic [CW-1:0]         occupancy;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;
    logic [CW:0]           pending;
    logic [CW:0]           limit;

    assign issue_addr     = WEIGHT_BASE + 32'(row_q) * 32'(WORDS_PER_ROW) + 32'(word_q);
    assign issue_row_last = (32'(word_q) == WORDS_PER_ROW - 1);
    assign issue_last     = issue_row_last && (rows_left_q == 8'd1);
    assign pop            = w_valid && w_ready;

    // A read issued now lands in the FIFO one cycle later; count the return
    // already on mem_rdata and credit back this cycle's pop.
    assign pending = (CW+1)'(occupancy) + (CW+1)'(inflight_q);
    assign limit   = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (row_count == 8'd0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (pending < limit) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // drain_armed_q keeps done off the first DRAIN cycle, so an
                // empty command still spends one cycle before completing.
                if (drain_armed_q && !inflight_q && fifo_empty) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            row_q          <= '0;
            word_q         <= '0;
            rows_left_q    <= '0;
            addr_q         <= '0;
            inflight_q     <= 1'b0;
            ret_row_last_q <= 1'b0;
            ret_last_q     <= 1'b0;
            drain_armed_q  <= 1'b0;
        end else begin
            state          <= state_next;
            inflight_q     <= issue;
            ret_row_last_q <= issue_row_last;
            ret_last_q     <= issue_last;
            drain_armed_q  <= (state == DRAIN);
            if (state == IDLE && start) begin
                row_q       <= row_start;
                word_q      <= '0;
                rows_left_q <= row_count;
            end
            if (issue) begin
                addr_q <= issue_addr;
                if (issue_row_last) begin
                    word_q      <= '0;
                    row_q       <= (row_q == ROW_IDX_W'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
                    rows_left_q <= rows_left_q - 8'd1;
                end else begin
                    word_q <= word_q + 1'b1;
                end
            end
        end
    end

    wq_fetch_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({mem_rdata, ret_row_last_q, ret_last_q}),
        .pop   (pop),
        .dout  (head),
        .count (occupancy),
        .empty (fifo_empty)
    );

    assign busy         = (state != IDLE) && !done;
    assign mem_addr     = issue ? issue_addr : addr_q;
    assign mem_write_en = 1'b0;
    assign w_valid      = !fifo_empty;
    assign w_data       = w_valid ? head[ENTRY_W-1:2] : '0;
    assign w_row_last   = w_valid && head[1];
    assign w_last       = w_valid && head[0];

endmodule

// File: tb/tb_wq_fetch.sv
// Self-checking bench for wq_fetch: a queue-based reference model of the
// expected word stream plus directed timing/address checks per transfer.
module tb_wq_fetch;
    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       row_start = '0;
    logic [7:0]       row_count = '0;
    logic             busy, done, mem_write_en;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_rdata, w_data;
    logic             w_valid, w_row_last, w_last;
    logic             w_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_ready = 0;
    int hs_cnt = 0, rl_cnt = 0, done_cnt = 0;

    typedef struct {
        logic [63:0] data;
        bit          rl;
        bit          last;
    } exp_t;
    exp_t expq[$];

    bit          pv_stall = 0;
    logic [63:0] pv_data;
    logic [1:0]  pv_flags;

    wq_fetch #(
        .WIDTH         (WIDTH),
        .WEIGHT_BASE   (32'd0),
        .NUM_ROWS      (128),
        .WORDS_PER_ROW (16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .row_start    (row_start),
        .row_count    (row_count),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_row_last   (w_row_last),
        .w_last       (w_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return {a ^ 32'h5A00_0000, a * 32'h9E37_79B9};
    endfunction

    always @(posedge clk) mem_rdata <= mem_word(mem_addr);

    function automatic logic [31:0] exp_addr(input int rs, input int idx);
        return 32'((((rs + idx / 16) % 128) * 16) + (idx % 16));
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic load_model(input int rs, input int rc);
        exp_t e;
        for (int i = 0; i < 16 * rc; i++) begin
            e.data = mem_word(exp_addr(rs, i));
            e.rl   = (i % 16 == 15);
            e.last = (i == 16 * rc - 1);
            expq.push_back(e);
        end
    endtask

    // Stream checker: every handshake must match the model head; held data must not change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_stall = 0;
                continue;
            end
            check_eq("mem_write_en", {63'd0, mem_write_en}, 64'd0);
            if (pv_stall) begin
                check_eq("hold_valid", {63'd0, w_valid}, 64'd1);
                check_eq("hold_data", w_data, pv_data);
                check_eq("hold_flags", {62'd0, w_row_last, w_last}, {62'd0, pv_flags});
            end
            if (w_valid && expq.size() == 0) begin
                check_eq("unexpected_valid", {63'd0, w_valid}, 64'd0);
            end else if (w_valid && w_ready) begin
                e = expq.pop_front();
                check_eq("w_data", w_data, e.data);
                check_eq("w_row_last", {63'd0, w_row_last}, {63'd0, e.rl});
                check_eq("w_last", {63'd0, w_last}, {63'd0, e.last});
                hs_cnt++;
                if (w_row_last) rl_cnt++;
            end
            if (done) done_cnt++;
            pv_stall = w_valid && !w_ready;
            pv_data  = w_data;
            pv_flags = {w_row_last, w_last};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            w_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_w_valid"}, {63'd0, w_valid}, 64'd0);
        check_eq({tag, "_w_row_last"}, {63'd0, w_row_last}, 64'd0);
        check_eq({tag, "_w_last"}, {63'd0, w_last}, 64'd0);
        check_eq({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check_eq({tag, "_mem_write_en"}, {63'd0, mem_write_en}, 64'd0);
        check_eq({tag, "_w_data"}, w_data, 64'd0);
    endtask

    // One command; glitch>0 pulses a bogus start at that cycle offset; pin_k>0 pins mem_addr to a literal.
    task automatic run_xfer(input int rs, input int rc, input bit timed, input bit check_addr,
                            input int glitch, input int pin_k, input logic [31:0] pin_addr);
        bit got;
        int done_k;
        @(posedge clk);
        #2;
        row_start = 7'(rs);
        row_count = 8'(rc);
        start     = 1'b1;
        load_model(rs, rc);
        hs_cnt = 0; rl_cnt = 0; done_cnt = 0;
        got = 0; done_k = 0;
        for (int k = 1; k <= 16 * rc * 8 + 40; k++) begin
            @(posedge clk);
            #2;
            start = (k == glitch);
            if (k == glitch) begin
                row_start = 7'($urandom);
                row_count = 8'($urandom_range(1, 128));
            end
            @(negedge clk);
            if (k == 1) check_eq("busy_after_start", {63'd0, busy}, 64'd1);
            if (check_addr && k <= 16 * rc) check_eq("mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr(rs, k - 1)});
            if (k == pin_k) check_eq("mem_addr_pinned", {32'd0, mem_addr}, {32'd0, pin_addr});
            if (done) begin
                got = 1;
                done_k = k;
                check_eq("busy_in_done_cycle", {63'd0, busy}, 64'd0);
                break;
            end
        end
        if (!got) check_eq("done_timeout", 64'd0, 64'd1);
        if (timed) check_eq("done_latency", 64'(done_k), 64'((rc == 0) ? 2 : 3 + 16 * rc));
        repeat (3) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            @(negedge clk);
            check_eq("busy_after_done", {63'd0, busy}, 64'd0);
        end
        check_eq("single_done", 64'(done_cnt), 64'd1);
        check_eq("words_delivered", 64'(hs_cnt), 64'(16 * rc));
        check_eq("row_last_count", 64'(rl_cnt), 64'(rc));
        check_eq("model_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_xfer(5, 1, 1, 1, 0, 1, 32'd80);
        run_xfer(5, 1, 1, 0, 0, 16, 32'd95);
        run_xfer(0, 128, 1, 1, 0, 2048, 32'd2047);

        rand_ready = 1;
        run_xfer(0, 128, 0, 0, 0, 0, 32'd0);
        rand_ready = 0;

        run_xfer(126, 4, 1, 1, 0, 33, 32'd0);
        run_xfer(0, 0, 1, 0, 0, 0, 32'd0);

        // Reset in the middle of row 3 of an 8-row transfer.
        @(posedge clk);
        #2;
        row_start = 7'd10;
        row_count = 8'd8;
        start     = 1'b1;
        load_model(10, 8);
        done_cnt = 0;
        repeat (54) begin
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        rst_n = 1'b0;
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("valid_after_reset", {63'd0, w_valid}, 64'd0);
        end
        check_eq("no_done_on_abort", 64'(done_cnt), 64'd0);
        run_xfer(0, 1, 1, 1, 0, 0, 32'd0);

        run_xfer(20, 2, 1, 1, 10, 0, 32'd0);
        run_xfer(40, 1, 1, 1, 19, 0, 32'd0);

        rand_ready = 1;
        for (int n = 0; n < 4; n++) begin
            run_xfer(int'($urandom_range(0, 127)), int'($urandom_range(1, 6)), 0, 0, 0, 0, 32'd0);
        end
        rand_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
